bht_btb_predictor: RTL and testbench

- Parametrised successor to the single global 2-bit predictor in the RISC-V turbo CPU.
- Provides per-PC direction prediction from an indexed table of saturating counters (bimodal or gshare mode), and a direct-mapped tagged branch target buffer.
- Lookup is combinational from the IF-stage PC; update is sequential from EX-stage branch resolution.
- Also counts resolved branches and mispredictions for performance analysis.

---
 rtl/bht_btb_predictor_pkg.sv | 21 ++
 rtl/bht_btb_predictor_sat_counter.sv | 37 +++
 rtl/bht_btb_predictor.sv | 109 ++++++++++
 tb/tb_bht_btb_predictor.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/bht_btb_predictor_pkg.sv
// Shared defaults, index-mode encodings and counter reset value for the
// branch direction/target predictor.
package bht_btb_predictor_pkg;

    localparam int DEF_ENTRIES = 64;
    localparam int DEF_CNT_W   = 2;
    localparam int DEF_GHR_W   = 6;

    typedef enum int {
        IDX_BIMODAL = 0,
        IDX_GSHARE  = 1
    } idx_mode_e;

    localparam int DEF_CNT_RST = 1 << (DEF_CNT_W - 1);

    // Weakly-taken start point for a counter of any width.
    function automatic int cnt_rst_val(input int cnt_w);
        return 1 << (cnt_w - 1);
    endfunction

endpackage

// File: rtl/bht_btb_predictor_sat_counter.sv
// Up/down saturating counter; one instance per direction-table entry.
module sat_counter
    import bht_btb_predictor_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_rst_val(CNT_W));
    localparam logic [CNT_W-1:0] MAX_VAL = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (inc && !dec && cnt_q != MAX_VAL)
                cnt_d = cnt_q + CNT_W'(1);
            else if (dec && !inc && cnt_q != '0)
                cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= RST_VAL;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/bht_btb_predictor.sv
// Per-PC branch predictor: saturating-counter direction table (bimodal or
// gshare index) plus a direct-mapped tagged BTB, with resolution counters.
module bht_btb_predictor
    import bht_btb_predictor_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = DEF_ENTRIES,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int GHR_W   = DEF_GHR_W,
    parameter int GSHARE  = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] lk_pc,
    output logic            lk_taken,
    output logic            lk_hit,
    output logic [PC_W-1:0] lk_target,
    input  logic            up_valid,
    input  logic [PC_W-1:0] up_pc,
    input  logic            up_taken,
    input  logic [PC_W-1:0] up_target,
    input  logic            up_mispred,
    output logic [31:0]     br_cnt,
    output logic [31:0]     mis_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX_W - 2;
    localparam bit USE_GHR = (GSHARE == int'(IDX_GSHARE));

    logic [IDX_W-1:0] lk_idx, up_idx, lk_cidx, up_cidx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [ENTRIES-1:0]            valid_q, valid_d;
    logic [ENTRIES-1:0][TAG_W-1:0] tag_q, tag_d;
    logic [ENTRIES-1:0][PC_W-1:0]  target_q, target_d;
    logic [ENTRIES-1:0][CNT_W-1:0] cnt;
    logic [31:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    logic unused_pc_bits;

    assign lk_idx = lk_pc[IDX_W+1:2];
    assign up_idx = up_pc[IDX_W+1:2];
    assign lk_tag = lk_pc[PC_W-1:IDX_W+2];
    assign up_tag = up_pc[PC_W-1:IDX_W+2];
    assign unused_pc_bits = ^{lk_pc[1:0], up_pc[1:0]};

    // Both paths hash with the current (pre-shift) history.
    assign lk_cidx = USE_GHR ? (lk_idx ^ IDX_W'(ghr_q)) : lk_idx;
    assign up_cidx = USE_GHR ? (up_idx ^ IDX_W'(ghr_q)) : up_idx;

    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken  = lk_hit && cnt[lk_cidx][CNT_W-1];
    assign lk_target = lk_hit ? target_q[lk_idx] : '0;
    assign br_cnt    = br_cnt_q;
    assign mis_cnt   = mis_cnt_q;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cnt
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (up_valid && (up_cidx == IDX_W'(i))),
            .inc (up_taken),
            .dec (!up_taken),
            .cnt (cnt[i])
        );
    end

    always_comb begin
        ghr_d     = ghr_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        target_d  = target_q;
        br_cnt_d  = br_cnt_q;
        mis_cnt_d = mis_cnt_q;
        if (up_valid) begin
            ghr_d = GHR_W'({ghr_q, up_taken});
            if (up_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = up_target;
            end
            if (br_cnt_q != '1)
                br_cnt_d = br_cnt_q + 32'd1;
            if (up_mispred && mis_cnt_q != '1)
                mis_cnt_d = mis_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q     <= '0;
            valid_q   <= '0;
            br_cnt_q  <= '0;
            mis_cnt_q <= '0;
        end else begin
            ghr_q     <= ghr_d;
            valid_q   <= valid_d;
            br_cnt_q  <= br_cnt_d;
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Tag/target payload is qualified by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Directed bench: bimodal instance for lookup/update/alias/counter checks,
// gshare instance for history-indexed counter selection.
module tb_bht_btb_predictor;

    logic        clk, rst;
    logic [31:0] lk_pc, up_pc, up_target, lk_target, br_cnt, mis_cnt;
    logic        lk_taken, lk_hit, up_valid, up_taken, up_mispred;
    logic [31:0] g_lk_pc, g_up_pc, g_up_target, g_lk_target, g_br_cnt, g_mis_cnt;
    logic        g_lk_taken, g_lk_hit, g_up_valid, g_up_taken, g_up_mispred;

    int n_checks = 0;
    int n_errors = 0;

    bht_btb_predictor dut (
        .clk(clk), .rst(rst), .lk_pc(lk_pc), .lk_taken(lk_taken), .lk_hit(lk_hit),
        .lk_target(lk_target), .up_valid(up_valid), .up_pc(up_pc), .up_taken(up_taken),
        .up_target(up_target), .up_mispred(up_mispred), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    bht_btb_predictor #(.GSHARE(1)) dut_g (
        .clk(clk), .rst(rst), .lk_pc(g_lk_pc), .lk_taken(g_lk_taken), .lk_hit(g_lk_hit),
        .lk_target(g_lk_target), .up_valid(g_up_valid), .up_pc(g_up_pc), .up_taken(g_up_taken),
        .up_target(g_up_target), .up_mispred(g_up_mispred), .br_cnt(g_br_cnt), .mis_cnt(g_mis_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg, input logic m);
        up_valid = 1'b1; up_pc = pc; up_taken = t; up_target = tg; up_mispred = m;
        @(posedge clk); #1;
        up_valid = 1'b0; up_taken = 1'b0; up_mispred = 1'b0;
    endtask

    task automatic gupd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        g_up_valid = 1'b1; g_up_pc = pc; g_up_taken = t; g_up_target = tg;
        @(posedge clk); #1;
        g_up_valid = 1'b0; g_up_taken = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lk_pc = pc; #1;
    endtask

    initial begin
        rst = 1'b1;
        lk_pc = '0; up_valid = 0; up_pc = '0; up_taken = 0; up_target = '0; up_mispred = 0;
        g_lk_pc = '0; g_up_valid = 0; g_up_pc = '0; g_up_taken = 0; g_up_target = '0; g_up_mispred = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        look(32'h1000);
        chk("rst_hit", lk_hit, 0);
        chk("rst_taken", lk_taken, 0);
        chk("rst_target", lk_target, 0);
        chk("rst_br", br_cnt, 0);
        chk("rst_mis", mis_cnt, 0);

        // first taken update allocates, counter 2->3
        upd(32'h1000, 1, 32'h2000, 0);
        look(32'h1000);
        chk("alloc_hit", lk_hit, 1);
        chk("alloc_target", lk_target, 32'h2000);
        chk("alloc_taken", lk_taken, 1);

        // not-taken walk 3->2->1->0, then hold at 0
        upd(32'h1000, 0, 32'h0, 0);
        chk("nt1_taken", lk_taken, 1);
        upd(32'h1000, 0, 32'h0, 0);
        chk("nt2_taken", lk_taken, 0);
        upd(32'h1000, 0, 32'h0, 0);
        chk("nt3_taken", lk_taken, 0);
        chk("nt3_hit", lk_hit, 1);
        upd(32'h1000, 0, 32'h0, 0);
        chk("nt4_taken", lk_taken, 0);
        upd(32'h1000, 1, 32'h2000, 0);
        chk("sat0_then_t", lk_taken, 0);

        // alias: 0x1100 shares index 0 with 0x1000, replaces tag
        upd(32'h1000, 1, 32'h2000, 0);
        upd(32'h1100, 1, 32'h3000, 0);
        look(32'h1000);
        chk("alias_old_hit", lk_hit, 0);
        chk("alias_old_taken", lk_taken, 0);
        chk("alias_old_target", lk_target, 0);
        look(32'h1100);
        chk("alias_new_hit", lk_hit, 1);
        chk("alias_new_target", lk_target, 32'h3000);
        chk("alias_new_taken", lk_taken, 1);
        chk("br_8", br_cnt, 8);
        chk("mis_0", mis_cnt, 0);

        // reset wins over a concurrent update
        rst = 1'b1;
        up_valid = 1; up_pc = 32'h1004; up_taken = 1; up_target = 32'h7777; up_mispred = 1;
        @(posedge clk); #1;
        rst = 1'b0; up_valid = 0; up_taken = 0; up_mispred = 0;
        chk("mrst_br", br_cnt, 0);
        chk("mrst_mis", mis_cnt, 0);
        look(32'h1100);
        chk("mrst_hit_1100", lk_hit, 0);
        look(32'h1004);
        chk("mrst_hit_1004", lk_hit, 0);

        // ten counted updates, four mispredicted, with same-cycle collisions
        upd(32'h1000, 1, 32'h2000, 1);
        upd(32'h1000, 0, 32'h0, 0);
        lk_pc = 32'h1000;
        up_valid = 1; up_pc = 32'h1000; up_taken = 0; up_target = '0; up_mispred = 1;
        #1;
        chk("coll_pre_taken", lk_taken, 1);
        @(posedge clk); #1;
        up_valid = 0; up_mispred = 0;
        chk("coll_post_taken", lk_taken, 0);
        lk_pc = 32'h2000;
        up_valid = 1; up_pc = 32'h2000; up_taken = 1; up_target = 32'h5000; up_mispred = 1;
        #1;
        chk("coll_pre_hit", lk_hit, 0);
        @(posedge clk); #1;
        up_valid = 0; up_taken = 0; up_mispred = 0;
        chk("coll_post_hit", lk_hit, 1);
        chk("coll_post_target", lk_target, 32'h5000);
        chk("coll_post_taken", lk_taken, 1);
        upd(32'h1004, 1, 32'h6000, 1);
        upd(32'h1004, 1, 32'h6000, 0);
        upd(32'h1004, 0, 32'h0, 0);
        upd(32'h1004, 0, 32'h0, 0);
        upd(32'h1004, 0, 32'h0, 0);
        upd(32'h1004, 0, 32'h0, 0);
        // idle cycle with garbage qualifiers must be ignored
        up_valid = 0; up_pc = 32'h1004; up_taken = 1; up_mispred = 1;
        @(posedge clk); #1;
        up_taken = 0; up_mispred = 0;
        look(32'h1004);
        chk("cnt_hit_1004", lk_hit, 1);
        chk("cnt_taken_1004", lk_taken, 0);
        chk("cnt_target_1004", lk_target, 32'h6000);
        chk("br_10", br_cnt, 10);
        chk("mis_4", mis_cnt, 4);

        // gshare: T,N,T at 0x1000 hits counters 0,1,2; GHR ends 3'b101.
        // Then T at 0x1028 (idx 10) -> GHR 6'b001011, lookup idx 10^11=1 (count 1).
        gupd(32'h1000, 1, 32'h2000);
        gupd(32'h1000, 0, 32'h0);
        gupd(32'h1000, 1, 32'h2000);
        gupd(32'h1028, 1, 32'h4000);
        g_lk_pc = 32'h1028; #1;
        chk("gs_hit_1028", g_lk_hit, 1);
        chk("gs_target_1028", g_lk_target, 32'h4000);
        chk("gs_taken_1028", g_lk_taken, 0);
        g_lk_pc = 32'h1000; #1;
        chk("gs_hit_1000", g_lk_hit, 1);
        chk("gs_taken_1000", g_lk_taken, 1);
        chk("gs_br", g_br_cnt, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
